// File: rtl/serial_addsub_if.sv
// Handshake and result bundle between a requester and the bit-serial add/subtract sequencer.
// The requester drives operands and start; the sequencer returns status and the registered result.
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             control;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, control,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, a, b, control,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused over WIDTH cycles, LSB first,
// with a registered result, carry-out, two's-complement overflow and a one-cycle done pulse.
module serial_addsub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum} of a single full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             ctl_q,    ctl_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [1:0]       fa_s;
    logic             msb_cin_s;

    // Next-state, datapath and output decode for the sequencer.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_sh_d  = res_sh_q;
        ctl_d     = ctl_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        msb_cin_s = carry_q;
        // Subtraction inverts B and seeds the carry with 1 (A + ~B + 1).
        fa_s      = full_add(a_sh_q[0], b_sh_q[0] ^ ctl_q, carry_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    ctl_d   = bus.control;
                    carry_d = bus.control;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {fa_s[0], res_sh_q[WIDTH-1:1]};
                carry_d  = fa_s[1];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = ST_DONE;
                    result_d = {fa_s[0], res_sh_q[WIDTH-1:1]};
                    cout_d   = fa_s[1];
                    ovf_d    = msb_cin_s ^ fa_s[1];
                end else begin
                    state_d  = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            ctl_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            ctl_q    <= ctl_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse.
module tb_serial_addsub_ctrl;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    exp_t exp_q[$];

    serial_addsub_if #(.WIDTH(W)) dif ();

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total = n_total + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (dif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total = n_total + 1;
                n_bad   = n_bad + 1;
                $display("FAIL unexpected_done: got done=1 want no pending operation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",   32'(dif.result),   32'(e.r));
                check("cout",     32'(dif.cout),     32'(e.c));
                check("overflow", 32'(dif.overflow), 32'(e.o));
            end
        end
    end

    // Issue one operation, expect busy for exactly W cycles and done within a bound.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ctl,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int nb;
        int cyc;
        @(negedge clk);
        dif.start   = 1'b1;
        dif.a       = a;
        dif.b       = b;
        dif.control = ctl;
        exp_q.push_back({er, ec, eo});
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        nb  = 0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (dif.done === 1'b1) break;
            if (dif.busy === 1'b1) nb = nb + 1;
        end
        check("done_latency", 32'(cyc), 32'(W + 1));
        check("busy_cycles",  32'(nb),  32'(W));
    endtask

    initial begin
        int n;
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b1;
        dif.start   = 1'b0;
        dif.a       = 4'b0000;
        dif.b       = 4'b0000;
        dif.control = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(dif.busy),     32'd0);
        check("rst_done",   32'(dif.done),     32'd0);
        check("rst_result", 32'(dif.result),   32'd0);
        check("rst_cout",   32'(dif.cout),     32'd0);
        check("rst_ovf",    32'(dif.overflow), 32'd0);
        rst = 1'b0;

        run_op(4'b0001, 4'b1010, 1'b0, 4'b1011, 1'b0, 1'b0);
        run_op(4'b1010, 4'b0010, 1'b1, 4'b1000, 1'b1, 1'b0);
        run_op(4'b0000, 4'b1110, 1'b1, 4'b0010, 1'b0, 1'b0);
        run_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);

        // Held start: operands swapped during RUN feed only the second, later operation.
        @(negedge clk);
        dif.start   = 1'b1;
        dif.a       = 4'b1111;
        dif.b       = 4'b0101;
        dif.control = 1'b1;
        exp_q.push_back({4'b1010, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        dif.a       = 4'b0010;
        dif.b       = 4'b0011;
        dif.control = 1'b0;
        exp_q.push_back({4'b0101, 1'b0, 1'b0});
        n = 0;
        while (n < 20 && dif.done !== 1'b1) begin
            @(negedge clk);
            n = n + 1;
        end
        check("held_first_latency", 32'(n), 32'(W + 1));
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
            if (n == 1) check("held_idle_after_done", 32'(dif.busy), 32'd0);
        end while (n < 20 && dif.done !== 1'b1);
        check("held_issue_interval", 32'(n), 32'(W + 2));
        dif.start = 1'b0;

        // Asynchronous reset two cycles into RUN discards the operation.
        @(negedge clk);
        dif.start   = 1'b1;
        dif.a       = 4'b0110;
        dif.b       = 4'b0001;
        dif.control = 1'b0;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",   32'(dif.busy),     32'd0);
        check("mid_rst_done",   32'(dif.done),     32'd0);
        check("mid_rst_result", 32'(dif.result),   32'd0);
        check("mid_rst_cout",   32'(dif.cout),     32'd0);
        check("mid_rst_ovf",    32'(dif.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dif.done === 1'b1 || dif.busy === 1'b1) n = n + 1;
        end
        check("no_done_after_rst", 32'(n), 32'd0);

        run_op(4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);

        // Result hold with start low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_result", 32'({dif.result, dif.cout, dif.overflow}), 32'({4'b0100, 1'b0, 1'b0}));
            check("hold_done",   32'(dif.done), 32'd0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract sequencer that schedules a single one-bit mode-controlled full-adder cell over WIDTH clock cycles to produce a WIDTH-bit sum or difference. It sits in front of the mode-control adder datapath. It captures operands and the mode on a start request, feeds one bit pair per cycle LSB-first with the carry held in a register, and presents a registered result with carry-out, overflow and a one-cycle done pulse.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- control  input  1  mode, captured on accepted start: 0 = A+B, 1 = A−B (A + ~B + 1)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE
- result  output  WIDTH  registered result; held until the next completion
- cout  output  1  final carry out; for subtract, 1 = no borrow
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge does the following:
  - loads shift registers with a and b;
  - latches control;
  - carry register ← control;
  - bit counter ← 0;
  - moves to RUN.
- RUN: each cycle the full-adder cell computes sum = a_sh[0] ^ (b_sh[0]^ctl) ^ carry and the matching carry.
  - Sum bit is shifted into the result shift register MSB-side.
  - Operands shift right; carry ← cell carry; counter increments.
  - At the counter value WIDTH−1 the cell's carry-in is recorded as the MSB carry-in, for overflow.
- After the edge processing bit WIDTH−1, RUN moves to DONE.
  - At the same edge result ← completed shift register, cout ← final carry, overflow ← msb_cin ^ final carry.
- DONE: done=1 for exactly one cycle, then unconditionally returns to IDLE.
- start is ignored in RUN and DONE. There is no queueing. A held start re-triggers only once back in IDLE.
- Operand/control input changes after acceptance have no effect on the operation in flight.
- result, cout and overflow change only at a completion edge or on reset.
- Width rule: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- rst asserted at any time, including mid-RUN, produces:
  - state → IDLE immediately;
  - busy=0, done=0, result=0, cout=0, overflow=0;
  - shift registers, carry and counter cleared.
  - The partial operation is discarded and no done pulse is produced.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0; state=IDLE.
- Start accepted at edge E0. busy is high from after E0 through the cycle ending at E_WIDTH.
- result, cout and overflow are valid and done=1 after edge E_WIDTH.
- done falls at E_WIDTH+1, which returns to IDLE.
- A new start can be accepted at E_WIDTH+2 at the earliest (first IDLE edge).
- Latency: WIDTH+1 cycles from the accepting edge to the done pulse; issue interval WIDTH+2 cycles.
- start and rst deasserting on the same edge: reset wins while high. start is sampled only at the first edge with rst low.

## Test plan
- Add, WIDTH=4: a=0001, b=1010, control=0 → after 5 edges done=1, result=1011, cout=0, overflow=0; busy high for exactly 4 cycles.
- Subtract: a=1010, b=0010, control=1 → result=1000, cout=1, overflow=0. Then a=0000, b=1110, control=1 → result=0010, cout=0, overflow=0.
- Overflow/wrap: a=0111, b=0001, control=0 → result=1000, overflow=1, cout=0. Then a=1111, b=0001, control=0 → result=0000, cout=1, overflow=0.
- Ignored start: start held high continuously, with a and b changed during RUN, for a=1111, b=0101, control=1 → result=1010, cout=1, overflow=0. A second operation begins only at the edge after done falls; exactly one done pulse per WIDTH+2 cycles.
- Mid-operation reset: assert rst asynchronously two cycles into RUN → outputs go to 0 immediately without waiting for an edge, and no done pulse follows. The next start with a=0011, b=0001, control=0 completes normally with result=0100.
- Result hold: after a completion, with start low for 10 cycles → result, cout and overflow stable and done stays 0.
